// File: rtl/sik_fetch.sv
// sik_fetch: dual-thread instruction fetch stage for the SIK stack processor.
// It alternates the two threads cycle by cycle and folds OPpre (4'hF) prefix
// words into the instruction that follows them. It also applies redirects and
// halts that come back from later stages.
// Optional build macro: SIK_FETCH_SKIP_HALTED_EN. When it is defined, a halted
// thread's slot is handed to the other thread if that thread is still live.
module sik_fetch #(
  parameter logic [15:0] T0_RESET_PC = 16'h0000,
  parameter logic [15:0] T1_RESET_PC = 16'h8000,
  parameter logic [15:0] NOOP_WORD   = 16'h003F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        redir_valid,
  input  logic        redir_thread,
  input  logic [15:0] redir_pc,
  input  logic        halt_req,
  input  logic        halt_thread,
  output logic [15:0] op_out,
  output logic        op_valid,
  output logic        op_thread,
  output logic [15:0] op_pc,
  output logic [3:0]  pre_out,
  output logic        pre_hit,
  output logic        all_halted
);

  // Per-thread architectural state
  logic [15:0] pc_reg       [2];
  logic [15:0] pc_next      [2];
  logic [3:0]  pre_val_reg  [2];
  logic [3:0]  pre_val_next [2];
  logic [1:0]  pre_pend_reg, pre_pend_next;
  logic [1:0]  halted_reg, halted_next;
  logic [1:0]  redir_hit, halt_hit, take;
  logic        turn_reg;
  logic        sel;
  logic        is_pre, squash, fetch_go;

  // Output registers
  logic [15:0] op_out_reg, op_pc_reg;
  logic        op_valid_reg, op_thread_reg, pre_hit_reg, all_halted_reg;
  logic [3:0]  pre_out_reg;

  // Choose which thread owns this cycle's fetch slot
  always_comb begin
    sel = turn_reg;
`ifdef SIK_FETCH_SKIP_HALTED_EN
    // A halted thread's slot goes to the other thread while that one is still live
    if (halted_reg[turn_reg] && !halted_reg[~turn_reg])
      sel = ~turn_reg;
`endif
  end

  assign imem_addr = pc_reg[sel];
  assign is_pre    = (imem_data[15:12] == 4'hF);
  // A redirect or halt aimed at the slot owner kills this slot's fetch
  assign squash    = redir_hit[sel] | halt_hit[sel];
  assign fetch_go  = !stall && !halted_reg[sel] && !squash;

  // Next-state logic per thread. A redirect overrides the sequential PC step.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_thread
      localparam logic TID = 1'(gi);
      assign redir_hit[gi]     = redir_valid && (redir_thread == TID);
      assign halt_hit[gi]      = halt_req && (halt_thread == TID);
      assign take[gi]          = fetch_go && (sel == TID);
      assign halted_next[gi]   = halted_reg[gi] | halt_hit[gi];
      assign pc_next[gi]       = redir_hit[gi] ? redir_pc :
                                 (take[gi] ? pc_reg[gi] + 16'd1 : pc_reg[gi]);
      assign pre_pend_next[gi] = redir_hit[gi] ? 1'b0 :
                                 (take[gi] ? is_pre : pre_pend_reg[gi]);
      assign pre_val_next[gi]  = (take[gi] && is_pre) ? imem_data[3:0] : pre_val_reg[gi];
    end
  endgenerate

  // State and output registers. Stall freezes the slot but still lets redirects and halts land.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg[0]      <= T0_RESET_PC;
      pc_reg[1]      <= T1_RESET_PC;
      pre_val_reg[0] <= 4'h0;
      pre_val_reg[1] <= 4'h0;
      pre_pend_reg   <= 2'b00;
      halted_reg     <= 2'b00;
      turn_reg       <= 1'b0;
      op_out_reg     <= NOOP_WORD;
      op_valid_reg   <= 1'b0;
      op_thread_reg  <= 1'b0;
      op_pc_reg      <= 16'h0000;
      pre_out_reg    <= 4'h0;
      pre_hit_reg    <= 1'b0;
      all_halted_reg <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        pc_reg[i]      <= pc_next[i];
        pre_val_reg[i] <= pre_val_next[i];
      end
      pre_pend_reg   <= pre_pend_next;
      halted_reg     <= halted_next;
      all_halted_reg <= &halted_next;
      if (!stall) begin
        turn_reg      <= ~turn_reg;
        op_thread_reg <= sel;
        op_pc_reg     <= pc_reg[sel];
        if (fetch_go && !is_pre) begin
          op_out_reg   <= imem_data;
          op_valid_reg <= 1'b1;
          pre_hit_reg  <= pre_pend_reg[sel];
          pre_out_reg  <= pre_val_reg[sel];
        end else begin
          // Bubble: halted slot, squashed slot, or a prefix word that was absorbed
          op_out_reg   <= NOOP_WORD;
          op_valid_reg <= 1'b0;
          pre_hit_reg  <= 1'b0;
          pre_out_reg  <= 4'h0;
        end
      end
    end
  end

  assign op_out     = op_out_reg;
  assign op_valid   = op_valid_reg;
  assign op_thread  = op_thread_reg;
  assign op_pc      = op_pc_reg;
  assign pre_out    = pre_out_reg;
  assign pre_hit    = pre_hit_reg;
  assign all_halted = all_halted_reg;

endmodule

// File: tb/tb_sik_fetch.sv
// tb_sik_fetch: self-checking bench for sik_fetch. A per-thread reference model
// (PCs, halt flags, pending prefixes and the turn bit) predicts each cycle's fetch.
module tb_sik_fetch;

  localparam logic [15:0] NOOP = 16'h003F;

  logic        clk = 1'b0;
  logic        reset, stall, redir_valid, redir_thread, halt_req, halt_thread;
  logic [15:0] imem_addr, imem_data, redir_pc, op_out, op_pc;
  logic        op_valid, op_thread, pre_hit, all_halted;
  logic [3:0]  pre_out;

  logic [15:0] mem [0:65535];
  assign imem_data = mem[imem_addr];

  always #5 clk = ~clk;

  sik_fetch dut (
    .clk(clk), .reset(reset), .stall(stall),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .redir_valid(redir_valid), .redir_thread(redir_thread), .redir_pc(redir_pc),
    .halt_req(halt_req), .halt_thread(halt_thread),
    .op_out(op_out), .op_valid(op_valid), .op_thread(op_thread), .op_pc(op_pc),
    .pre_out(pre_out), .pre_hit(pre_hit), .all_halted(all_halted)
  );

  int vectors = 0;
  int errors  = 0;

  // Reference model state
  logic [15:0] m_pc [2];
  bit          m_halt [2];
  bit          m_pp [2];
  logic [3:0]  m_pv [2];
  bit          m_turn;
  // Expected outputs
  logic [15:0] e_out, e_pc, exp_addr, got_addr;
  logic        e_valid, e_thr, e_hit, e_all, e_noop;
  logic [3:0]  e_pre;

  task automatic model_reset();
    m_pc[0] = 16'h0000; m_pc[1] = 16'h8000;
    m_halt[0] = 0; m_halt[1] = 0; m_pp[0] = 0; m_pp[1] = 0;
    m_pv[0] = 4'h0; m_pv[1] = 4'h0; m_turn = 0;
    e_out = NOOP; e_valid = 0; e_thr = 0; e_pc = 16'h0; e_pre = 4'h0; e_hit = 0;
    e_all = 0; e_noop = 1;
  endtask

  // Apply one cycle of inputs, predict the result, advance one edge
  task automatic step(input logic s, input logic rv, input logic rt, input logic [15:0] rp,
                      input logic hv, input logic ht);
    logic t;
    logic [15:0] d;
    logic sq;
    stall = s; redir_valid = rv; redir_thread = rt; redir_pc = rp;
    halt_req = hv; halt_thread = ht;
    #1;
    got_addr = imem_addr;
    t = m_turn;
`ifdef SIK_FETCH_SKIP_HALTED_EN
    if (m_halt[t] && !m_halt[!t]) t = !t;
`endif
    exp_addr = m_pc[t];
    d = mem[m_pc[t]];
    sq = (rv && rt == t) || (hv && ht == t);
    if (!s) begin
      m_turn = !m_turn;
      e_valid = 0;
      e_noop = 0;
      if (m_halt[t]) begin
        e_out = NOOP;
        e_noop = 1;
      end else if (!sq) begin
        if (d[15:12] == 4'hF) begin
          m_pp[t] = 1;
          m_pv[t] = d[3:0];
        end else begin
          e_valid = 1; e_out = d; e_thr = t; e_pc = m_pc[t];
          e_hit = m_pp[t]; e_pre = m_pv[t]; m_pp[t] = 0;
        end
        m_pc[t] = m_pc[t] + 16'd1;
      end
    end
    if (rv) begin m_pc[rt] = rp; m_pp[rt] = 0; end
    if (hv) m_halt[ht] = 1;
    e_all = m_halt[0] && m_halt[1];
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; stall = 1'b0; redir_valid = 1'b0; halt_req = 1'b0;
    redir_thread = 1'b0; halt_thread = 1'b0; redir_pc = 16'h0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'($urandom); redir_valid = 1'($urandom);
    redir_thread = 1'($urandom); redir_pc = 16'($urandom);
    halt_req = 1'($urandom); halt_thread = 1'($urandom);
    @(posedge clk); #1;
    reset = 1'b0; stall = 1'b0; redir_valid = 1'b0; halt_req = 1'b0;
    model_reset();
    vectors++;
    if (op_out !== NOOP) begin errors++; $display("FAIL reset_op_out: got %h want %h", op_out, NOOP); end
    if (op_valid !== 1'b0) begin errors++; $display("FAIL reset_op_valid: got %b want 0", op_valid); end
    if (op_thread !== 1'b0) begin errors++; $display("FAIL reset_op_thread: got %b want 0", op_thread); end
    if (op_pc !== 16'h0000) begin errors++; $display("FAIL reset_op_pc: got %h want 0000", op_pc); end
    if (pre_out !== 4'h0) begin errors++; $display("FAIL reset_pre_out: got %h want 0", pre_out); end
    if (pre_hit !== 1'b0) begin errors++; $display("FAIL reset_pre_hit: got %b want 0", pre_hit); end
    if (all_halted !== 1'b0) begin errors++; $display("FAIL reset_all_halted: got %b want 0", all_halted); end
    if (imem_addr !== 16'h0000) begin errors++; $display("FAIL reset_imem_addr: got %h want 0000", imem_addr); end
    $display("reset: op_out=%h op_valid=%b imem_addr=%h", op_out, op_valid, imem_addr);
  endtask

  task automatic test_fetch_prefix();
    do_reset();
    mem[16'h0000] = 16'h1001; mem[16'h8000] = 16'h8005;
    mem[16'h0001] = 16'hF00A; mem[16'h8001] = 16'h8006;
    mem[16'h0002] = 16'hF00B; mem[16'h8002] = 16'h8007;
    mem[16'h0003] = 16'h0001; mem[16'h8003] = 16'h8008;
    mem[16'h0004] = 16'h0002; mem[16'h8004] = 16'h8009;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      vectors++;
      if (got_addr !== exp_addr) begin errors++; $display("FAIL fetch_addr step %0d: got %h want %h", i, got_addr, exp_addr); end
      if ({op_valid, all_halted} !== {e_valid, e_all}) begin errors++; $display("FAIL fetch_valid step %0d: got %b%b want %b%b", i, op_valid, all_halted, e_valid, e_all); end
      if (e_valid && {op_out, op_thread, op_pc, pre_out, pre_hit} !== {e_out, e_thr, e_pc, e_pre, e_hit}) begin
        errors++; $display("FAIL fetch_op step %0d: got %h t%b pc %h pre %h/%b want %h t%b pc %h pre %h/%b", i, op_out, op_thread, op_pc, pre_out, pre_hit, e_out, e_thr, e_pc, e_pre, e_hit);
      end
      $display("fetch step %0d: valid=%b thr=%b pc=%h op=%h pre=%h/%b", i, op_valid, op_thread, op_pc, op_out, pre_out, pre_hit);
    end
  endtask

  task automatic test_redirect_wrap();
    logic rv;
    logic [15:0] rp;
    do_reset();
    mem[16'h0000] = 16'hF00C; mem[16'h0001] = 16'h0777;
    mem[16'h0040] = 16'h1234; mem[16'h0041] = 16'h1235;
    mem[16'hFFFF] = 16'h0AAA;
    for (int i = 0; i < 8; i++) mem[16'h8000 + 16'(i)] = 16'h7000 + 16'(i);
    for (int i = 0; i < 12; i++) begin
      rv = (i == 2) || (i == 5);
      rp = (i == 2) ? 16'h0040 : 16'hFFFF;
      step(1'b0, rv, 1'b0, rp, 1'b0, 1'b0);
      vectors++;
      if (got_addr !== exp_addr) begin errors++; $display("FAIL redir_addr step %0d: got %h want %h", i, got_addr, exp_addr); end
      if ({op_valid, all_halted} !== {e_valid, e_all}) begin errors++; $display("FAIL redir_valid step %0d: got %b%b want %b%b", i, op_valid, all_halted, e_valid, e_all); end
      if (e_valid && {op_out, op_thread, op_pc, pre_out, pre_hit} !== {e_out, e_thr, e_pc, e_pre, e_hit}) begin
        errors++; $display("FAIL redir_op step %0d: got %h t%b pc %h pre %h/%b want %h t%b pc %h pre %h/%b", i, op_out, op_thread, op_pc, pre_out, pre_hit, e_out, e_thr, e_pc, e_pre, e_hit);
      end
      $display("redirect step %0d: valid=%b thr=%b pc=%h op=%h pre=%h/%b", i, op_valid, op_thread, op_pc, op_out, pre_out, pre_hit);
    end
  endtask

  task automatic test_stall();
    logic s;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      mem[16'(i)] = 16'h0100 + 16'(i);
      mem[16'h8000 + 16'(i)] = 16'h0200 + 16'(i);
    end
    for (int i = 0; i < 10; i++) begin
      s = (i >= 3) && (i <= 5);
      step(s, (i == 4), 1'b1, 16'h8004, 1'b0, 1'b0);
      vectors++;
      if (got_addr !== exp_addr) begin errors++; $display("FAIL stall_addr step %0d: got %h want %h", i, got_addr, exp_addr); end
      if ({op_valid, all_halted} !== {e_valid, e_all}) begin errors++; $display("FAIL stall_valid step %0d: got %b%b want %b%b", i, op_valid, all_halted, e_valid, e_all); end
      if (e_valid && {op_out, op_thread, op_pc, pre_out, pre_hit} !== {e_out, e_thr, e_pc, e_pre, e_hit}) begin
        errors++; $display("FAIL stall_op step %0d: got %h t%b pc %h want %h t%b pc %h", i, op_out, op_thread, op_pc, e_out, e_thr, e_pc);
      end
      $display("stall step %0d: stall=%b valid=%b thr=%b pc=%h op=%h addr=%h", i, s, op_valid, op_thread, op_pc, op_out, got_addr);
    end
  endtask

  task automatic test_halt();
    logic hv;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      mem[16'(i)] = 16'h0300 + 16'(i);
      mem[16'h8000 + 16'(i)] = 16'h0400 + 16'(i);
    end
    for (int i = 0; i < 13; i++) begin
      hv = (i == 2) || (i == 9);
      step(1'b0, 1'b0, 1'b0, 16'h0, hv, (i == 2));
      vectors++;
      if (got_addr !== exp_addr) begin errors++; $display("FAIL halt_addr step %0d: got %h want %h", i, got_addr, exp_addr); end
      if ({op_valid, all_halted} !== {e_valid, e_all}) begin errors++; $display("FAIL halt_valid step %0d: got %b%b want %b%b", i, op_valid, all_halted, e_valid, e_all); end
      if (e_noop && op_out !== NOOP) begin errors++; $display("FAIL halt_noop step %0d: got %h want %h", i, op_out, NOOP); end
      if (e_valid && {op_out, op_thread, op_pc} !== {e_out, e_thr, e_pc}) begin
        errors++; $display("FAIL halt_op step %0d: got %h t%b pc %h want %h t%b pc %h", i, op_out, op_thread, op_pc, e_out, e_thr, e_pc);
      end
      $display("halt step %0d: valid=%b thr=%b pc=%h op=%h all_halted=%b", i, op_valid, op_thread, op_pc, op_out, all_halted);
    end
  endtask

  task automatic test_random();
    logic s, rv, hv;
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int a = 0; a < 65536; a++)
        mem[a] = ($urandom_range(0, 4) == 0) ? {4'hF, 12'($urandom)} : {4'($urandom_range(0, 14)), 12'($urandom)};
      for (int i = 0; i < 300; i++) begin
        s  = ($urandom_range(0, 3) == 0);
        rv = ($urandom_range(0, 9) == 0);
        hv = ($urandom_range(0, 119) == 0);
        step(s, rv, 1'($urandom), 16'($urandom), hv, 1'($urandom));
        vectors++;
        if (got_addr !== exp_addr) begin errors++; $display("FAIL rand_addr r%0d step %0d: got %h want %h", r, i, got_addr, exp_addr); end
        if ({op_valid, all_halted} !== {e_valid, e_all}) begin errors++; $display("FAIL rand_valid r%0d step %0d: got %b%b want %b%b", r, i, op_valid, all_halted, e_valid, e_all); end
        if (e_noop && op_out !== NOOP) begin errors++; $display("FAIL rand_noop r%0d step %0d: got %h want %h", r, i, op_out, NOOP); end
        if (e_valid && {op_out, op_thread, op_pc, pre_out, pre_hit} !== {e_out, e_thr, e_pc, e_pre, e_hit}) begin
          errors++; $display("FAIL rand_op r%0d step %0d: got %h t%b pc %h pre %h/%b want %h t%b pc %h pre %h/%b", r, i, op_out, op_thread, op_pc, pre_out, pre_hit, e_out, e_thr, e_pc, e_pre, e_hit);
        end
        $display("random r%0d step %0d: stall=%b valid=%b thr=%b pc=%h op=%h", r, i, s, op_valid, op_thread, op_pc, op_out);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 7; i++)
      step(1'b0, 1'b0, 1'b0, 16'h0, (i == 3), 1'b1);
    reset = 1'b1; stall = 1'b0; redir_valid = 1'b1; redir_thread = 1'b0;
    redir_pc = 16'h1234; halt_req = 1'b1; halt_thread = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; redir_valid = 1'b0; halt_req = 1'b0;
    model_reset();
    vectors++;
    if ({op_out, op_valid, op_thread, op_pc} !== {NOOP, 1'b0, 1'b0, 16'h0000}) begin
      errors++; $display("FAIL midreset_op: got %h %b %b %h want %h 0 0 0000", op_out, op_valid, op_thread, op_pc, NOOP);
    end
    if ({pre_out, pre_hit, all_halted} !== {4'h0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL midreset_pre: got %h %b %b want 0 0 0", pre_out, pre_hit, all_halted);
    end
    if (imem_addr !== 16'h0000) begin errors++; $display("FAIL midreset_addr: got %h want 0000", imem_addr); end
    $display("mid reset: op_out=%h op_valid=%b all_halted=%b imem_addr=%h", op_out, op_valid, all_halted, imem_addr);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redir_valid = 1'b0; redir_thread = 1'b0;
    redir_pc = 16'h0; halt_req = 1'b0; halt_thread = 1'b0;
    for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_fetch_prefix();
    test_redirect_wrap();
    test_stall();
    test_halt();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/sik_fetch.md
Name: sik_fetch

Overview:
Dual-thread instruction fetch stage for the SIK stack processor. It sits directly upstream of the decode block.
- Keeps one PC, one halted flag and one pending-prefix register per thread.
- Interleaves the two threads cycle by cycle.
- Absorbs OPpre (4'hF) prefix words, so decode receives each instruction already tagged with its prefix nibble.
- Applies branch redirects and halt requests coming back from later stages.

Parameters:
- T0_RESET_PC, 16'h0000, thread 0 start address
- T1_RESET_PC, 16'h8000, thread 1 start address
- NOOP_WORD, 16'h003F, value driven on op_out when idle or at reset

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- stall  in  1  downstream not ready; hold all state and outputs
- imem_addr  out  16  instruction memory word address (combinational)
- imem_data  in  16  instruction word at imem_addr (same-cycle, combinational memory)
- redir_valid  in  1  PC redirect request (jump/call/ret taken)
- redir_thread  in  1  thread being redirected
- redir_pc  in  16  new PC for that thread
- halt_req  in  1  sys/halt retired
- halt_thread  in  1  thread to halt
- op_out  out  16  fetched instruction word to decode
- op_valid  out  1  op_out holds a real instruction
- op_thread  out  1  thread owning op_out
- op_pc  out  16  address of op_out
- pre_out  out  4  prefix nibble attached to op_out
- pre_hit  out  1  pre_out is meaningful
- all_halted  out  1  both threads halted

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset state:
  - pc0=T0_RESET_PC, pc1=T1_RESET_PC
  - turn=0, halted=2'b00, pre_pend=2'b00, pre_val=0
  - op_out=NOOP_WORD, op_valid=0, op_thread=0, op_pc=0, pre_out=0, pre_hit=0, all_halted=0
- Slot selection:
  - Selected thread t=turn; imem_addr=pc[t] at all times, including during stall.
  - turn toggles on every cycle where stall=0.
- Normal fetch (stall=0, !halted[t], no squash, imem_data[15:12]!=4'hF):
  - Next edge: op_out<=imem_data, op_valid<=1, op_thread<=t, op_pc<=pc[t], pc[t]<=pc[t]+1.
  - pre_hit<=pre_pend[t] and pre_out<=pre_val[t]; then pre_pend[t]<=0.
  - Latency is 1 cycle from imem_addr to op_out.
- Prefix word (imem_data[15:12]==4'hF):
  - pre_pend[t]<=1, pre_val[t]<=imem_data[3:0], pc[t]<=pc[t]+1, op_valid<=0.
  - The prefix consumes the slot. A second consecutive prefix overwrites pre_val.
- Halted thread's slot: op_valid<=0 and op_out<=NOOP_WORD. PC is unchanged.
- Redirect (redir_valid):
  - pc[redir_thread]<=redir_pc and pre_pend[redir_thread]<=0.
  - Takes effect even when stall=1.
  - If redir_thread==t in a non-stalled cycle, that slot is squashed: op_valid<=0 and the PC does not increment.
- Halt (halt_req):
  - halted[halt_thread]<=1, sticky until reset.
  - Same-cycle fetch by that thread is squashed.
  - Halt and redirect to the same thread in the same cycle: PC loads redir_pc and the halt still applies.
- Stall (stall=1): op_*, pre_*, turn, and pc/pre state hold, except for redirect and halt updates.
- all_halted is registered: all_halted<=(next halted==2'b11), so it rises on the edge the second halt lands.
- PC arithmetic is 16-bit modulo; 16'hFFFF+1 wraps to 16'h0000.
- Reset mid-operation discards pending prefixes, redirects and halted flags.

Optional Feature:
- Macro: SIK_FETCH_SKIP_HALTED_EN
- Defined: when turn selects a halted thread and the other thread is not halted, the slot is given to the other thread. imem_addr, op_thread and the PC update all use the other thread. turn still toggles. A single live thread therefore fetches every cycle.
- Undefined: a halted thread's slots produce bubbles (op_valid=0).

Test Plan:
1. Reset, then memory[0]=16'h1001, memory[16'h8000]=16'h8005, 4 cycles of stall=0 → op_valid=1 with (thread0, pc 0, 16'h1001), then (thread1, pc 8000, 16'h8005), then pc 1, then pc 8001, alternating.
2. memory[0]=16'hF00A, memory[1]=16'h0001 → thread-0 slot 1 gives op_valid=0; thread-0 slot 2 gives op_out=16'h0001, pre_hit=1, pre_out=4'hA; the following thread-0 op has pre_hit=0.
3. redir_valid=1, redir_thread=0, redir_pc=16'h0040 during a thread-0 slot → that slot has op_valid=0; next thread-0 op_pc=16'h0040; a pending prefix on thread 0 is cleared.
4. stall=1 for 3 cycles mid-stream → op_out, op_pc and imem_addr constant; resumes with no lost or duplicated op.
5. halt_req thread 1, then halt_req thread 0 → thread-1 slots become bubbles (or, with SIK_FETCH_SKIP_HALTED_EN, thread 0 fetches every cycle: pc 2, 3, 4...); all_halted=1 one edge after the second halt.
6. pc0=16'hFFFF via redirect → next thread-0 op_pc=16'hFFFF, the one after is 16'h0000. Asserting reset mid-stream → all outputs return to their reset values on the next edge.
